arp_responder: RTL and testbench

- Answers ARP requests for the FPGA's IP address so that a PC can resolve our MAC address before exchanging UDP traffic.
- Sits between the 10BASE-T Rx byte deframer (rx_* side) and the 10BASE-T frame transmitter (tx_* side).
- The Rx side delivers de-preambled frame bytes and a CRC verdict. The Tx side prepends preamble/SFD and appends CRC32.

---
 rtl/arp_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_arp_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_responder.sv
// ARP responder: checks incoming ARP requests for MY_IP and answers with MY_PA.
// Define ARP_PAD_EN to zero-pad replies to 60 bytes; otherwise replies are 42 bytes.
module arp_responder #(
  parameter logic [47:0] MY_PA = 48'h16FD2204B161,
  parameter logic [31:0] MY_IP = 32'hC0A80165
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_frame,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_end,
  input  logic        rx_crc_ok,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] reply_count
);

`ifdef ARP_PAD_EN
  localparam logic [5:0] LastIdx = 6'd59;
`else
  localparam logic [5:0] LastIdx = 6'd41;
`endif

  typedef enum logic [1:0] {StIdle, StRx, StTx} state_e;

  state_e      state_q, state_d;
  logic        rx_frame_q;
  logic [5:0]  rx_idx_q, rx_idx_d;
  logic        good_q, good_d;
  logic        bcast_q, bcast_d;
  logic        ucast_q, ucast_d;
  logic [7:0]  sha_q [6];
  logic [7:0]  sha_d [6];
  logic [7:0]  spa_q [4];
  logic [7:0]  spa_d [4];
  logic [5:0]  tx_idx_q, tx_idx_d;
  logic [15:0] count_q, count_d;

  logic        rx_rise;
  logic        rx_take;
  logic        has_exp;
  logic [7:0]  exp_val;
  logic [5:0]  off_sha, off_spa, off_ip;
  logic [5:0]  tx_off;
  logic [7:0]  tx_byte;

  function automatic logic [7:0] pa_byte(input logic [2:0] k);
    case (k)
      3'd0:    pa_byte = MY_PA[47:40];
      3'd1:    pa_byte = MY_PA[39:32];
      3'd2:    pa_byte = MY_PA[31:24];
      3'd3:    pa_byte = MY_PA[23:16];
      3'd4:    pa_byte = MY_PA[15:8];
      default: pa_byte = MY_PA[7:0];
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] k);
    case (k)
      2'd0:    ip_byte = MY_IP[31:24];
      2'd1:    ip_byte = MY_IP[23:16];
      2'd2:    ip_byte = MY_IP[15:8];
      default: ip_byte = MY_IP[7:0];
    endcase
  endfunction

  assign rx_rise = rx_frame & ~rx_frame_q;
  assign rx_take = rx_byte_valid & ((state_q == StRx) | ((state_q == StIdle) & rx_rise));

  always_comb begin
    state_d  = state_q;
    rx_idx_d = rx_idx_q;
    good_d   = good_q;
    bcast_d  = bcast_q;
    ucast_d  = ucast_q;
    sha_d    = sha_q;
    spa_d    = spa_q;
    tx_idx_d = tx_idx_q;
    count_d  = count_q;
    has_exp  = 1'b0;
    exp_val  = 8'h00;
    off_sha  = 6'd0;
    off_spa  = 6'd0;
    off_ip   = 6'd0;

    // Parser state is re-armed every idle cycle so a byte on the rising edge is usable.
    if (state_q == StIdle) begin
      rx_idx_d = 6'd0;
      good_d   = 1'b1;
      bcast_d  = 1'b1;
      ucast_d  = 1'b1;
      tx_idx_d = 6'd0;
    end

    if (rx_take) begin
      off_sha = rx_idx_d - 6'd22;
      off_spa = rx_idx_d - 6'd28;
      off_ip  = rx_idx_d - 6'd38;
      if (rx_idx_d < 6'd6) begin
        bcast_d = bcast_d & (rx_byte == 8'hFF);
        ucast_d = ucast_d & (rx_byte == pa_byte(rx_idx_d[2:0]));
      end
      case (rx_idx_d)
        6'd12: begin has_exp = 1'b1; exp_val = 8'h08; end
        6'd13: begin has_exp = 1'b1; exp_val = 8'h06; end
        6'd14: begin has_exp = 1'b1; exp_val = 8'h00; end
        6'd15: begin has_exp = 1'b1; exp_val = 8'h01; end
        6'd16: begin has_exp = 1'b1; exp_val = 8'h08; end
        6'd17: begin has_exp = 1'b1; exp_val = 8'h00; end
        6'd18: begin has_exp = 1'b1; exp_val = 8'h06; end
        6'd19: begin has_exp = 1'b1; exp_val = 8'h04; end
        6'd20: begin has_exp = 1'b1; exp_val = 8'h00; end
        6'd21: begin has_exp = 1'b1; exp_val = 8'h01; end
        6'd38, 6'd39, 6'd40, 6'd41: begin
          has_exp = 1'b1;
          exp_val = ip_byte(off_ip[1:0]);
        end
        default: has_exp = 1'b0;
      endcase
      if (has_exp && (rx_byte != exp_val)) good_d = 1'b0;
      if ((rx_idx_d >= 6'd22) && (rx_idx_d < 6'd28)) sha_d[off_sha[2:0]] = rx_byte;
      if ((rx_idx_d >= 6'd28) && (rx_idx_d < 6'd32)) spa_d[off_spa[1:0]] = rx_byte;
      if (rx_idx_d != 6'd63) rx_idx_d = rx_idx_d + 6'd1;
    end

    unique case (state_q)
      StIdle: if (rx_rise) state_d = StRx;
      StRx: begin
        if (rx_end) begin
          if (good_d && (bcast_d || ucast_d) && rx_crc_ok && (rx_idx_d >= 6'd42)) begin
            state_d = StTx;
          end else begin
            state_d = StIdle;
          end
        end else if (!rx_frame) begin
          state_d = StIdle;
        end
      end
      StTx: begin
        if (tx_ready) begin
          if (tx_idx_q == LastIdx) begin
            state_d  = StIdle;
            tx_idx_d = 6'd0;
            count_d  = count_q + 16'd1;
          end else begin
            tx_idx_d = tx_idx_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reply byte selected purely from tx_idx and captured fields, so it holds through stalls.
  always_comb begin
    tx_byte = 8'h00;
    tx_off  = 6'd0;
    if (tx_idx_q < 6'd6) begin
      tx_byte = sha_q[tx_idx_q[2:0]];
    end else if (tx_idx_q < 6'd12) begin
      tx_off  = tx_idx_q - 6'd6;
      tx_byte = pa_byte(tx_off[2:0]);
    end else if (tx_idx_q < 6'd22) begin
      case (tx_idx_q)
        6'd12:   tx_byte = 8'h08;
        6'd13:   tx_byte = 8'h06;
        6'd15:   tx_byte = 8'h01;
        6'd16:   tx_byte = 8'h08;
        6'd18:   tx_byte = 8'h06;
        6'd19:   tx_byte = 8'h04;
        6'd21:   tx_byte = 8'h02;
        default: tx_byte = 8'h00;
      endcase
    end else if (tx_idx_q < 6'd28) begin
      tx_off  = tx_idx_q - 6'd22;
      tx_byte = pa_byte(tx_off[2:0]);
    end else if (tx_idx_q < 6'd32) begin
      tx_off  = tx_idx_q - 6'd28;
      tx_byte = ip_byte(tx_off[1:0]);
    end else if (tx_idx_q < 6'd38) begin
      tx_off  = tx_idx_q - 6'd32;
      tx_byte = sha_q[tx_off[2:0]];
    end else if (tx_idx_q < 6'd42) begin
      tx_off  = tx_idx_q - 6'd38;
      tx_byte = spa_q[tx_off[1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rx_frame_q <= 1'b0;
      rx_idx_q   <= 6'd0;
      good_q     <= 1'b0;
      bcast_q    <= 1'b0;
      ucast_q    <= 1'b0;
      for (int i = 0; i < 6; i++) sha_q[i] <= 8'h00;
      for (int i = 0; i < 4; i++) spa_q[i] <= 8'h00;
      tx_idx_q   <= 6'd0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      rx_frame_q <= rx_frame;
      rx_idx_q   <= rx_idx_d;
      good_q     <= good_d;
      bcast_q    <= bcast_d;
      ucast_q    <= ucast_d;
      sha_q      <= sha_d;
      spa_q      <= spa_d;
      tx_idx_q   <= tx_idx_d;
      count_q    <= count_d;
    end
  end

  assign tx_valid    = (state_q == StTx);
  assign tx_last     = tx_valid & (tx_idx_q == LastIdx);
  assign tx_data     = tx_valid ? tx_byte : 8'h00;
  assign busy        = tx_valid;
  assign reply_count = count_q;

endmodule

// File: tb/tb_arp_responder.sv
// Directed bench for arp_responder: broadcast/unicast requests, rejects, stalls, mid-TX reset.
module tb_arp_responder;

`ifdef ARP_PAD_EN
  localparam int N = 60;
`else
  localparam int N = 42;
`endif
  localparam logic [47:0] PA   = 48'h16FD2204B161;
  localparam logic [31:0] IP   = 32'hC0A80165;
  localparam logic [47:0] SHA1 = 48'h001122334455;
  localparam logic [31:0] SPA1 = 32'hC0A80164;
  localparam logic [47:0] SHA2 = 48'h66778899AABB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_frame = 1'b0;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_end = 1'b0;
  logic        rx_crc_ok = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] reply_count;

  int checks = 0;
  int failures = 0;
  int n;
  logic [7:0] frm [64];

  arp_responder dut (
    .clk          (clk),
    .rst          (rst),
    .rx_frame     (rx_frame),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .rx_end       (rx_end),
    .rx_crc_ok    (rx_crc_ok),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .reply_count  (reply_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] b48(input logic [47:0] v, input int k);
    logic [47:0] t;
    t = v >> (8 * (5 - k));
    return t[7:0];
  endfunction

  function automatic logic [7:0] b32(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v >> (8 * (3 - k));
    return t[7:0];
  endfunction

  // ARP fixed header bytes 12..21; op is the last byte (1 = request, 2 = reply).
  function automatic logic [7:0] hdr(input int k, input logic [7:0] op);
    case (k)
      0: return 8'h08;  1: return 8'h06;  2: return 8'h00;  3: return 8'h01;
      4: return 8'h08;  5: return 8'h00;  6: return 8'h06;  7: return 8'h04;
      8: return 8'h00;  default: return op;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [47:0] sha,
                                          input logic [31:0] spa);
    if (i < 6)  return b48(sha, i);
    if (i < 12) return b48(PA, i - 6);
    if (i < 22) return hdr(i - 12, 8'h02);
    if (i < 28) return b48(PA, i - 22);
    if (i < 32) return b32(IP, i - 28);
    if (i < 38) return b48(sha, i - 32);
    if (i < 42) return b32(spa, i - 38);
    return 8'h00;
  endfunction

  task automatic build_req(input bit bcast, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [31:0] tip);
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frm[i]      = bcast ? 8'hFF : b48(PA, i);
      frm[6 + i]  = b48(sha, i);
      frm[22 + i] = b48(sha, i);
    end
    for (int i = 0; i < 10; i++) frm[12 + i] = hdr(i, 8'h01);
    for (int i = 0; i < 4; i++) begin
      frm[28 + i] = b32(spa, i);
      frm[38 + i] = b32(tip, i);
    end
  endtask

  task automatic send_frame(input int len, input logic crc);
    @(posedge clk); #1 rx_frame = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1 rx_byte_valid = 1'b1; rx_byte = frm[i];
    end
    @(posedge clk); #1 rx_byte_valid = 1'b0; rx_end = 1'b1; rx_crc_ok = crc;
    @(posedge clk); #1 rx_end = 1'b0; rx_frame = 1'b0; rx_crc_ok = 1'b0;
  endtask

  // pat 0: ready always high; pat 1: ready follows 1,0,0,1. stop_after 0 = run to tx_last.
  task automatic collect(input int pat, input int stop_after, input logic [47:0] sha,
                         input logic [31:0] spa, output int cnt);
    logic       held;
    logic [7:0] hd;
    logic       hl;
    int         cyc;
    bit         done;
    cnt = 0; held = 1'b0; hd = 8'h00; hl = 1'b0; cyc = 0; done = 1'b0;
    while (!done) begin
      tx_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (cyc == 0) begin
        check("first_valid", tx_valid, 1);
        check("first_busy", busy, 1);
      end
      if (held) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, hd);
        check("stall_last", tx_last, hl);
      end
      held = tx_valid & ~tx_ready;
      hd   = tx_data;
      hl   = tx_last;
      if (tx_valid && tx_ready) begin
        check($sformatf("tx_data[%0d]", cnt), tx_data, exp_byte(cnt, sha, spa));
        check($sformatf("tx_last[%0d]", cnt), tx_last, (cnt == N - 1));
        cnt++;
        if (cnt == N || cnt == stop_after) done = 1'b1;
      end
      cyc++;
      if (cyc > 400) begin
        check("collect_timeout", cyc, 0);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
  endtask

  task automatic expect_silent(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_valid || busy) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_count", reply_count, 0);

    // Broadcast request
    build_req(1'b1, SHA1, SPA1, IP);
    send_frame(60, 1'b1);
    collect(0, 0, SHA1, SPA1, n);
    check("bcast_len", n, N);
    check("bcast_count", reply_count, 1);
    check("bcast_idle_valid", tx_valid, 0);
    check("bcast_idle_busy", busy, 0);

    // Wrong target IP
    do_reset();
    build_req(1'b1, SHA1, SPA1, 32'hC0A80166);
    send_frame(60, 1'b1);
    expect_silent("wrong_ip_silent", 80);
    check("wrong_ip_count", reply_count, 0);

    // Bad CRC
    build_req(1'b1, SHA1, SPA1, IP);
    send_frame(60, 1'b0);
    expect_silent("bad_crc_silent", 80);
    check("bad_crc_count", reply_count, 0);

    // Unicast request with stalls
    do_reset();
    build_req(1'b0, SHA1, SPA1, IP);
    send_frame(60, 1'b1);
    collect(1, 0, SHA1, SPA1, n);
    check("ucast_len", n, N);
    check("ucast_count", reply_count, 1);

    // Truncated request
    do_reset();
    build_req(1'b1, SHA1, SPA1, IP);
    send_frame(30, 1'b1);
    expect_silent("trunc_silent", 80);
    check("trunc_count", reply_count, 0);

    // Second request arriving during TX is ignored
    do_reset();
    build_req(1'b1, SHA1, SPA1, IP);
    send_frame(60, 1'b1);
    fork
      collect(1, 0, SHA1, SPA1, n);
      begin
        repeat (3) @(posedge clk);
        #1 build_req(1'b1, SHA2, SPA1, IP);
        send_frame(60, 1'b1);
      end
    join
    check("overlap_len", n, N);
    check("overlap_count", reply_count, 1);
    expect_silent("overlap_silent", 100);
    check("overlap_count_after", reply_count, 1);

    // Reset mid-TX, then a fresh request
    build_req(1'b1, SHA1, SPA1, IP);
    send_frame(60, 1'b1);
    collect(0, 10, SHA1, SPA1, n);
    check("midrst_partial", n, 10);
    rst = 1'b1;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", reply_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    build_req(1'b1, SHA2, SPA1, IP);
    send_frame(60, 1'b1);
    collect(0, 0, SHA2, SPA1, n);
    check("after_rst_len", n, N);
    check("after_rst_count", reply_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
